// File: rtl/exponentiation_param_pkg.sv
// Shared types for the modular exponentiation engine: controller states and
// index-width helpers.
package exp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    TOMONT,
    SCAN,
    SQUARE,
    MULT,
    NEXT,
    FROMMONT,
    DONE
  } exp_state_e;

  localparam int DEFAULT_EXP_WIDTH = 512;
  localparam int IDX_W = $clog2(DEFAULT_EXP_WIDTH);

  // A 1-bit exponent still needs a 1-bit index register.
  function automatic int idx_width(input int exp_width);
    return (exp_width > 1) ? $clog2(exp_width) : 1;
  endfunction

endpackage

// File: rtl/exponentiation_param_if.sv
// Host-facing request/result bundle of the exponentiation engine.
interface exponentiation_param_if #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512
);
  logic                 start;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     modulus;
  logic [EXP_WIDTH-1:0] exponent;
  logic [WIDTH-1:0]     Rmodm;
  logic [WIDTH-1:0]     Rsquaredmodm;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     A_result;

  modport master (
    output start, x, modulus, exponent, Rmodm, Rsquaredmodm,
    input  busy, done, A_result
  );

  modport slave (
    input  start, x, modulus, exponent, Rmodm, Rsquaredmodm,
    output busy, done, A_result
  );
endinterface

// File: rtl/exponentiation_param_mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = in_a * in_b * 2^-WIDTH mod in_m.
// One operand bit per cycle, then a final conditional subtraction cycle.
module mont_mul #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] acc_add;
  logic [WIDTH+1:0] acc_odd;
  logic [CW-1:0]    cnt;
  logic             running;

  // acc stays below 2m, so two guard bits cover acc + b + m.
  always_comb begin
    acc_add = acc + (a_sh[0] ? {2'b00, b_r} : '0);
    acc_odd = acc_add + (acc_add[0] ? {2'b00, m_r} : '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_sh    <= '0;
      b_r     <= '0;
      m_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !running) begin
        a_sh    <= in_a;
        b_r     <= in_b;
        m_r     <= in_m;
        acc     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (cnt == CW'(WIDTH)) begin
          running <= 1'b0;
          done    <= 1'b1;
          result  <= (acc >= {2'b00, m_r}) ? WIDTH'(acc - {2'b00, m_r}) : acc[WIDTH-1:0];
        end else begin
          acc  <= acc_odd >> 1;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/exponentiation_param.sv
// Left-to-right square-and-multiply modular exponentiation over one shared
// Montgomery multiplier, with leading-zero skipping or constant-time operation.
module exponentiation_param
  import exp_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int EXP_WIDTH  = 512,
  parameter bit CONST_TIME = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  exponentiation_param_if.slave bus
);

  localparam int IW = idx_width(EXP_WIDTH);

  exp_state_e state, state_n;

  logic [WIDTH-1:0]     x_r, m_r, rm_r, r2_r;
  logic [WIDTH-1:0]     a_r, xm_r, res_r;
  logic [EXP_WIDTH-1:0] e_r;
  logic [IW-1:0]        idx;
  logic                 busy_r, done_r;
  logic                 mul_wait, mul_start, mul_done;
  logic [WIDTH-1:0]     op_a, op_b, mul_res;
  logic                 cur_bit;

  assign cur_bit      = e_r[idx];
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.A_result = res_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Multiply states fire one start pulse on entry, then hold until mont_mul reports done.
  always_comb begin
    state_n   = state;
    mul_start = 1'b0;
    op_a      = a_r;
    op_b      = a_r;
    unique case (state)
      IDLE:     if (bus.start) state_n = LOAD;
      LOAD:     state_n = TOMONT;
      TOMONT: begin
        op_a      = x_r;
        op_b      = r2_r;
        mul_start = !mul_wait;
        if (mul_done) state_n = CONST_TIME ? SQUARE : SCAN;
      end
      SCAN: begin
        if (cur_bit)         state_n = SQUARE;
        else if (idx == '0)  state_n = FROMMONT;
      end
      SQUARE: begin
        mul_start = !mul_wait;
        if (mul_done) state_n = (cur_bit || CONST_TIME) ? MULT : NEXT;
      end
      MULT: begin
        op_b      = xm_r;
        mul_start = !mul_wait;
        if (mul_done) state_n = NEXT;
      end
      NEXT:     state_n = (idx == '0) ? FROMMONT : SQUARE;
      FROMMONT: begin
        op_b      = WIDTH'(1);
        mul_start = !mul_wait;
        if (mul_done) state_n = DONE;
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_r      <= '0;
      m_r      <= '0;
      rm_r     <= '0;
      r2_r     <= '0;
      e_r      <= '0;
      a_r      <= '0;
      xm_r     <= '0;
      res_r    <= '0;
      idx      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      mul_wait <= 1'b0;
    end else begin
      if (mul_start)     mul_wait <= 1'b1;
      else if (mul_done) mul_wait <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          x_r    <= bus.x;
          m_r    <= bus.modulus;
          e_r    <= bus.exponent;
          rm_r   <= bus.Rmodm;
          r2_r   <= bus.Rsquaredmodm;
          busy_r <= 1'b1;
          done_r <= 1'b0;
        end
        LOAD: begin
          a_r <= rm_r;
          idx <= IW'(EXP_WIDTH - 1);
        end
        TOMONT:   if (mul_done) xm_r <= mul_res;
        SCAN:     if (!cur_bit && idx != '0) idx <= idx - 1'b1;
        SQUARE:   if (mul_done) a_r <= mul_res;
        MULT:     if (mul_done && cur_bit) a_r <= mul_res;
        NEXT:     if (idx != '0) idx <= idx - 1'b1;
        FROMMONT: if (mul_done) a_r <= mul_res;
        DONE: begin
          res_r  <= a_r;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mont_mul #(.WIDTH(WIDTH)) u_mont (
    .clk    (clk),
    .resetn (resetn),
    .start  (mul_start),
    .in_a   (op_a),
    .in_b   (op_b),
    .in_m   (m_r),
    .result (mul_res),
    .done   (mul_done)
  );

endmodule

// File: tb/tb_exponentiation_param.sv
// Randomised self-checking bench: three engine configurations checked against a
// plain-arithmetic pow(x,e,m) model, plus literal expectations from hand calculation.
`timescale 1ns/1ps
module tb_exponentiation_param;
  import exp_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exponentiation_param_if #(.WIDTH(16),  .EXP_WIDTH(16)) i0 ();
  exponentiation_param_if #(.WIDTH(16),  .EXP_WIDTH(16)) i1 ();
  exponentiation_param_if #(.WIDTH(512), .EXP_WIDTH(8))  i2 ();

  exponentiation_param #(.WIDTH(16),  .EXP_WIDTH(16), .CONST_TIME(1'b0)) d0 (.clk(clk), .resetn(resetn), .bus(i0));
  exponentiation_param #(.WIDTH(16),  .EXP_WIDTH(16), .CONST_TIME(1'b1)) d1 (.clk(clk), .resetn(resetn), .bus(i1));
  exponentiation_param #(.WIDTH(512), .EXP_WIDTH(8),  .CONST_TIME(1'b0)) d2 (.clk(clk), .resetn(resetn), .bus(i2));

  int           checks = 0;
  int           errors = 0;
  int           pulses [3] = '{0, 0, 0};
  int           base [3];
  logic [511:0] expect_res [3];
  bit           armed [3] = '{1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [511:0] mod_mul(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
    logic [513:0] acc;
    acc = '0;
    for (int i = 511; i >= 0; i--) begin
      acc = acc << 1;
      if (acc >= {2'b00, m}) acc = acc - {2'b00, m};
      if (b[i]) begin
        acc = acc + {2'b00, a};
        if (acc >= {2'b00, m}) acc = acc - {2'b00, m};
      end
    end
    return acc[511:0];
  endfunction

  function automatic logic [511:0] pow2_mod(input logic [511:0] m, input int n);
    logic [512:0] r;
    r = 513'd1;
    for (int i = 0; i < n; i++) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[511:0];
  endfunction

  function automatic logic [511:0] pow_mod(input logic [511:0] x, input logic [511:0] e,
                                           input logic [511:0] m, input int ew);
    logic [511:0] r;
    r = 512'd1;
    for (int i = ew - 1; i >= 0; i--) begin
      r = mod_mul(r, r, m);
      if (e[i]) r = mod_mul(r, x, m);
    end
    return r;
  endfunction

  function automatic int count_ops(input logic [511:0] e, input int ew, input bit ct);
    int n, pc;
    if (ct) return 2 + 2 * ew;
    n = 0;
    pc = 0;
    for (int i = 0; i < ew; i++) if (e[i]) begin n = i + 1; pc++; end
    return 2 + n + pc;
  endfunction

  // ---------------- DUT access helpers ----------------
  function automatic logic get_busy(input int k);
    case (k)
      0: return i0.busy;
      1: return i1.busy;
      default: return i2.busy;
    endcase
  endfunction

  function automatic logic get_done(input int k);
    case (k)
      0: return i0.done;
      1: return i1.done;
      default: return i2.done;
    endcase
  endfunction

  function automatic logic [511:0] get_res(input int k);
    case (k)
      0: return 512'(i0.A_result);
      1: return 512'(i1.A_result);
      default: return i2.A_result;
    endcase
  endfunction

  task automatic drive(input int k, input logic s, input logic [511:0] x, input logic [511:0] m,
                       input logic [511:0] e, input logic [511:0] rm, input logic [511:0] r2);
    case (k)
      0: begin
        i0.start = s; i0.x = x[15:0]; i0.modulus = m[15:0]; i0.exponent = e[15:0];
        i0.Rmodm = rm[15:0]; i0.Rsquaredmodm = r2[15:0];
      end
      1: begin
        i1.start = s; i1.x = x[15:0]; i1.modulus = m[15:0]; i1.exponent = e[15:0];
        i1.Rmodm = rm[15:0]; i1.Rsquaredmodm = r2[15:0];
      end
      default: begin
        i2.start = s; i2.x = x; i2.modulus = m; i2.exponent = e[7:0];
        i2.Rmodm = rm; i2.Rsquaredmodm = r2;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (d0.mul_start) pulses[0]++;
    if (d1.mul_start) pulses[1]++;
    if (d2.mul_start) pulses[2]++;
  end

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (resetn) begin
      for (int k = 0; k < 3; k++) begin
        if (armed[k] && get_done(k)) begin
          check($sformatf("d%0d result", k), get_res(k), expect_res[k]);
          check($sformatf("d%0d busy low while done", k), 512'(get_busy(k)), 512'd0);
        end
      end
    end
  end

  task automatic applyStimulus(input int k, input logic [511:0] x, input logic [511:0] m, input logic [511:0] e);
    int w, ew;
    w  = (k == 2) ? 512 : 16;
    ew = (k == 2) ? 8 : 16;
    armed[k] = 1'b0;
    expect_res[k] = pow_mod(x, e, m, ew);
    @(negedge clk);
    drive(k, 1'b1, x, m, e, pow2_mod(m, w), pow2_mod(m, 2 * w));
    base[k] = pulses[k];
    @(negedge clk);
    drive(k, 1'b0, {16{$urandom()}}, {16{$urandom()}}, {16{$urandom()}}, {16{$urandom()}}, {16{$urandom()}});
    check($sformatf("d%0d busy after accept", k), 512'(get_busy(k)), 512'd1);
    check($sformatf("d%0d done cleared after accept", k), 512'(get_done(k)), 512'd0);
    armed[k] = 1'b1;
  endtask

  task automatic waitDone(input int k, output int lat, output int np);
    lat = 0;
    while (!get_done(k) && lat < 15000) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("d%0d done within bound", k), 512'(get_done(k)), 512'd1);
    np = pulses[k] - base[k];
  endtask

  task automatic checkOutput(input int k, input logic [511:0] lit, input int np, input int np_req);
    check($sformatf("d%0d literal result", k), get_res(k), lit);
    check($sformatf("d%0d done", k), 512'(get_done(k)), 512'd1);
    check($sformatf("d%0d busy", k), 512'(get_busy(k)), 512'd0);
    check($sformatf("d%0d mont_mul pulses", k), 512'(np), 512'(np_req));
  endtask

  initial begin
    logic [511:0] m, x, e;
    int lat_a, lat_b, np, guard;

    for (int k = 0; k < 3; k++) drive(k, 1'b0, '0, '0, '0, '0, '0);

    check("model R mod m", pow2_mod(512'hD5, 16), 512'h91);
    check("model R^2 mod m", pow2_mod(512'hD5, 32), 512'h97);
    check("model 3^5 mod 213", pow_mod(512'h3, 512'h5, 512'hD5, 16), 512'h1E);
    check("model op count", 512'(count_ops(512'h5, 16, 1'b0)), 512'd7);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d reset busy", k), 512'(get_busy(k)), 512'd0);
      check($sformatf("d%0d reset done", k), 512'(get_done(k)), 512'd0);
      check($sformatf("d%0d reset result", k), get_res(k), 512'd0);
    end
    resetn = 1'b1;

    $display("[TB] scenario 1/2: basic and constant-time");
    applyStimulus(0, 512'h3, 512'hD5, 512'h5);
    waitDone(0, lat_a, np);
    checkOutput(0, 512'h1E, np, 7);

    applyStimulus(1, 512'h3, 512'hD5, 512'h5);
    waitDone(1, lat_a, np);
    checkOutput(1, 512'h1E, np, 34);
    applyStimulus(1, 512'h3, 512'hD5, 512'hFFFF);
    waitDone(1, lat_b, np);
    check("d1 pulses all-ones exponent", 512'(np), 512'd34);
    check("d1 latency independent of exponent", 512'(lat_b), 512'(lat_a));

    $display("[TB] scenario 3/4: boundary exponents and ignored start");
    applyStimulus(0, 512'h3, 512'hD5, 512'h0);
    waitDone(0, lat_a, np);
    checkOutput(0, 512'h1, np, 2);

    applyStimulus(0, 512'h50, 512'hD5, 512'h1);
    @(negedge clk);
    i0.exponent = 16'h0002;
    i0.start = 1'b1;
    @(negedge clk);
    i0.start = 1'b0;
    waitDone(0, lat_a, np);
    checkOutput(0, 512'h50, np, 4);

    for (int v = 0; v < 6; v++) begin
      x = 512'($urandom_range(0, 212));
      e = 512'($urandom_range(0, 16'hFFFF));
      applyStimulus(0, x, 512'hD5, e);
      waitDone(0, lat_a, np);
      check("d0 random pulses", 512'(np), 512'(count_ops(e, 16, 1'b0)));
    end

    $display("[TB] scenario 5: reset mid-run");
    applyStimulus(0, 512'h3, 512'hD5, 512'h5);
    guard = 0;
    while (d0.state != SQUARE && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("d0 reached SQUARE", 512'(d0.state == SQUARE), 512'd1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) armed[k] = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("d0 busy cleared by reset", 512'(i0.busy), 512'd0);
    check("d0 done cleared by reset", 512'(i0.done), 512'd0);
    check("d0 result cleared by reset", 512'(i0.A_result), 512'd0);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(0, 512'h3, 512'hD5, 512'h5);
    waitDone(0, lat_a, np);
    checkOutput(0, 512'h1E, np, 7);

    $display("[TB] scenario 6: 512-bit random sweep");
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 16; j++) m[j*32 +: 32] = $urandom();
      m[511] = 1'b1;
      m[0]   = 1'b1;
      for (int j = 0; j < 16; j++) x[j*32 +: 32] = $urandom();
      x = x % m;
      e = (v == 0) ? 512'h80 : 512'($urandom_range(1, 255));
      applyStimulus(2, x, m, e);
      waitDone(2, lat_a, np);
      check("d2 pulses", 512'(np), 512'(count_ops(e, 8, 1'b0)));
      repeat (4) @(negedge clk);
      check("d2 done holds", 512'(i2.done), 512'd1);
      check("d2 result holds", i2.A_result, expect_res[2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
